// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU datapath.
// Moore FSM stepping T0..T7 per instruction; outputs decode from state and the opcode latched in T2.
module control_sequencer #(
    parameter logic [11:0] ADD_CODE = 12'h001,
    parameter logic [11:0] SUB_CODE = 12'h002,
    parameter logic [11:0] AND_CODE = 12'h004,
    parameter logic [11:0] OR_CODE  = 12'h008
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        PCin,
    output logic        Zlowout,
    output logic        MDRRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin_in,
    output logic        Rout_in,
    output logic        BAout,
    output logic        RAMread,
    output logic        RAMwrite,
    output logic [11:0] ALUControl,
    output logic        Run,
    output logic        InstrDone
);

    // state  | meaning
    // RESET  | one cycle after clr release, all outputs idle
    // T0..T2 | fetch: PC to MAR, memory read into MDR, MDR to IR
    // T3..T7 | execute, length depends on the latched opcode
    // HALT   | idle until clr
    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, next_state;
    logic [4:0] opcode_q;
    logic       is_ld, is_ldi, is_st, is_alu, is_halt, is_mem_imm;
    logic [11:0] alu_code;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= ST_RESET;
            opcode_q <= 5'd0;
        end else begin
            state <= next_state;
            if (state == ST_T2) begin
                opcode_q <= IR[31:27];
            end
        end
    end

    assign is_ld      = (opcode_q == OP_LD);
    assign is_ldi     = (opcode_q == OP_LDI);
    assign is_st      = (opcode_q == OP_ST);
    assign is_halt    = (opcode_q == OP_HALT);
    assign is_alu     = (opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                        (opcode_q == OP_AND) || (opcode_q == OP_OR);
    assign is_mem_imm = is_ld || is_ldi || is_st;

    always_comb begin
        alu_code = ADD_CODE;
        case (opcode_q)
            OP_SUB:  alu_code = SUB_CODE;
            OP_AND:  alu_code = AND_CODE;
            OP_OR:   alu_code = OR_CODE;
            default: alu_code = ADD_CODE;
        endcase
    end

    always_comb begin
        next_state = state;
        PCout = 1'b0;   MARin = 1'b0;   IncPC = 1'b0;    Zin = 1'b0;
        PCin = 1'b0;    Zlowout = 1'b0; MDRRead = 1'b0;  MDRin = 1'b0;
        MDRout = 1'b0;  IRin = 1'b0;    Yin = 1'b0;      Cout = 1'b0;
        Gra = 1'b0;     Grb = 1'b0;     Grc = 1'b0;      Rin_in = 1'b0;
        Rout_in = 1'b0; BAout = 1'b0;   RAMread = 1'b0;  RAMwrite = 1'b0;
        ALUControl = 12'd0;
        InstrDone = 1'b0;
        Run = 1'b1;
        case (state)
            ST_RESET: begin
                Run = 1'b0;
                next_state = ST_T0;
            end
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; RAMread = 1'b1; MDRRead = 1'b1; MDRin = 1'b1;
                next_state = ST_T2;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = ST_T3;
            end
            ST_T3: begin
                if (is_alu) begin
                    Grb = 1'b1; Rout_in = 1'b1; Yin = 1'b1;
                    next_state = ST_T4;
                end else if (is_mem_imm) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    next_state = ST_T4;
                end else begin
                    // nop, halt and unrecognised opcodes all finish here
                    InstrDone = 1'b1;
                    next_state = (is_halt || Stop) ? ST_HALT : ST_T0;
                end
            end
            ST_T4: begin
                Zin = 1'b1;
                ALUControl = is_alu ? alu_code : ADD_CODE;
                if (is_alu) begin
                    Grc = 1'b1; Rout_in = 1'b1;
                end else begin
                    Cout = 1'b1;
                end
                next_state = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    MARin = 1'b1;
                    next_state = ST_T6;
                end else begin
                    Gra = 1'b1; Rin_in = 1'b1; InstrDone = 1'b1;
                    next_state = Stop ? ST_HALT : ST_T0;
                end
            end
            ST_T6: begin
                MDRin = 1'b1;
                if (is_ld) begin
                    RAMread = 1'b1; MDRRead = 1'b1;
                end else begin
                    Gra = 1'b1; Rout_in = 1'b1;
                end
                next_state = ST_T7;
            end
            ST_T7: begin
                InstrDone = 1'b1;
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                end else begin
                    RAMwrite = 1'b1;
                end
                next_state = Stop ? ST_HALT : ST_T0;
            end
            ST_HALT: begin
                Run = 1'b0;
                next_state = ST_HALT;
            end
            default: begin
                Run = 1'b0;
                next_state = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors checked against hand-written tables.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR = 32'h0880_0085;
    logic        Stop = 1'b0;
    logic PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin, MDRout, IRin, Yin, Cout;
    logic Gra, Grb, Grc, Rin_in, Rout_in, BAout, RAMread, RAMwrite, Run, InstrDone;
    logic [11:0] alu;
    logic [21:0] obs;

    int errors = 0;
    int checks = 0;

    localparam logic [21:0] RUN   = 22'd1 << 0;
    localparam logic [21:0] IDONE = 22'd1 << 1;
    localparam logic [21:0] RAMW  = 22'd1 << 2;
    localparam logic [21:0] RAMR  = 22'd1 << 3;
    localparam logic [21:0] BAO   = 22'd1 << 4;
    localparam logic [21:0] ROUT  = 22'd1 << 5;
    localparam logic [21:0] RIN   = 22'd1 << 6;
    localparam logic [21:0] GRC   = 22'd1 << 7;
    localparam logic [21:0] GRB   = 22'd1 << 8;
    localparam logic [21:0] GRA   = 22'd1 << 9;
    localparam logic [21:0] COUT  = 22'd1 << 10;
    localparam logic [21:0] YIN   = 22'd1 << 11;
    localparam logic [21:0] IRIN  = 22'd1 << 12;
    localparam logic [21:0] MDRO  = 22'd1 << 13;
    localparam logic [21:0] MDRIN = 22'd1 << 14;
    localparam logic [21:0] MDRRD = 22'd1 << 15;
    localparam logic [21:0] ZLO   = 22'd1 << 16;
    localparam logic [21:0] PCIN  = 22'd1 << 17;
    localparam logic [21:0] ZIN   = 22'd1 << 18;
    localparam logic [21:0] INCPC = 22'd1 << 19;
    localparam logic [21:0] MARIN = 22'd1 << 20;
    localparam logic [21:0] PCOUT = 22'd1 << 21;
    localparam logic [21:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [21:0] F1 = ZLO | PCIN | RAMR | MDRRD | MDRIN | RUN;
    localparam logic [21:0] F2 = MDRO | IRIN | RUN;

    assign obs = {PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin, MDRout, IRin, Yin,
                  Cout, Gra, Grb, Grc, Rin_in, Rout_in, BAout, RAMread, RAMwrite, InstrDone, Run};

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin), .Zlowout(Zlowout),
        .MDRRead(MDRRead), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin_in(Rin_in), .Rout_in(Rout_in), .BAout(BAout),
        .RAMread(RAMread), .RAMwrite(RAMwrite), .ALUControl(alu), .Run(Run), .InstrDone(InstrDone)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs !== 22'd0 || alu !== 12'd0) begin
            errors++;
            $display("FAIL reset_held: got %h/%h expected 000000/000", obs, alu);
        end
        clr = 1'b1;
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL reset_cycle: got %h expected 000000", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== F0) begin
            errors++;
            $display("FAIL reset_to_t0: got %h expected %h", obs, F0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs !== (COUT | ZIN | RUN) || alu !== 12'h001) begin
            errors++;
            $display("FAIL pre_abort_t4: got %h/%h expected %h/001", obs, alu, COUT | ZIN | RUN);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (obs !== 22'd0 || alu !== 12'd0) begin
            errors++;
            $display("FAIL async_abort: got %h/%h expected 000000/000", obs, alu);
        end
        @(negedge clk);
        clr = 1'b1;
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL abort_reset_cycle: got %h expected 000000", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== F0) begin
            errors++;
            $display("FAIL abort_restart_t0: got %h expected %h", obs, F0);
        end
    endtask

    task automatic test_ldi();
        logic [21:0] exp_o [7];
        logic [11:0] exp_a [7];
        exp_o = '{F0, F1, F2, GRB | BAO | YIN | RUN, COUT | ZIN | RUN,
                  ZLO | GRA | RIN | IDONE | RUN, F0};
        exp_a = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h001, 12'h0, 12'h0};
        IR = 32'h0880_0085;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs !== exp_o[i] || alu !== exp_a[i]) begin
                errors++;
                $display("FAIL ldi_t%0d: got %h/%h expected %h/%h", i, obs, alu, exp_o[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_st();
        logic [21:0] exp_o [9];
        logic [11:0] exp_a [9];
        exp_o = '{F0, F1, F2, GRB | BAO | YIN | RUN, COUT | ZIN | RUN, ZLO | MARIN | RUN,
                  GRA | ROUT | MDRIN | RUN, RAMW | IDONE | RUN, F0};
        exp_a = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h001, 12'h0, 12'h0, 12'h0, 12'h0};
        IR = {5'b00010, 27'h0123456};
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs !== exp_o[i] || alu !== exp_a[i]) begin
                errors++;
                $display("FAIL st_t%0d: got %h/%h expected %h/%h", i, obs, alu, exp_o[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_sub_unknown();
        logic [21:0] exp_o [7];
        logic [11:0] exp_a [7];
        logic [21:0] nop_o [5];
        exp_o = '{F0, F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | RUN,
                  ZLO | GRA | RIN | IDONE | RUN, F0};
        exp_a = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h002, 12'h0, 12'h0};
        nop_o = '{F0, F1, F2, IDONE | RUN, F0};
        IR = {5'b00100, 27'h0};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs !== exp_o[i] || alu !== exp_a[i]) begin
                errors++;
                $display("FAIL sub_t%0d: got %h/%h expected %h/%h", i, obs, alu, exp_o[i], exp_a[i]);
            end
        end
        IR = {5'b11111, 27'h7FFFFFF};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs !== nop_o[i] || alu !== 12'h0) begin
                errors++;
                $display("FAIL unknown_t%0d: got %h/%h expected %h/000", i, obs, alu, nop_o[i]);
            end
        end
    endtask

    task automatic test_ir_corrupt();
        logic [21:0] exp_o [7];
        logic [11:0] exp_a [7];
        exp_o = '{F0, F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | RUN,
                  ZLO | GRA | RIN | IDONE | RUN, F0};
        exp_a = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h001, 12'h0, 12'h0};
        IR = {5'b00011, 27'h0};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3) IR = 32'h0;
            checks++;
            if (obs !== exp_o[i] || alu !== exp_a[i]) begin
                errors++;
                $display("FAIL add_corrupt_t%0d: got %h/%h expected %h/%h", i, obs, alu, exp_o[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_stop_halt();
        logic [21:0] exp_o [6];
        int bad;
        exp_o = '{F0, F1, F2, GRB | BAO | YIN | RUN, COUT | ZIN | RUN, ZLO | GRA | RIN | IDONE | RUN};
        IR = 32'h0880_0085;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            Stop = (i == 3) || (i == 5);
            checks++;
            if (obs !== exp_o[i]) begin
                errors++;
                $display("FAIL stop_ldi_t%0d: got %h expected %h", i, obs, exp_o[i]);
            end
        end
        @(negedge clk);
        Stop = 1'b0;
        checks++;
        if (obs !== 22'd0 || Run !== 1'b0) begin
            errors++;
            $display("FAIL stop_to_halt: got %h expected 000000", obs);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obs !== 22'd0 || alu !== 12'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL halt_persist: got %0d active cycles expected 0", bad);
        end
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL halt_clr_reset: got %h expected 000000", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== F0) begin
            errors++;
            $display("FAIL halt_clr_t0: got %h expected %h", obs, F0);
        end
    endtask

    task automatic test_halt_opcode();
        logic [21:0] exp_o [7];
        exp_o = '{F0, F1, F2, IDONE | RUN, 22'd0, 22'd0, 22'd0};
        IR = {5'b11011, 27'h0};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs !== exp_o[i] || alu !== 12'h0) begin
                errors++;
                $display("FAIL halt_op_t%0d: got %h/%h expected %h/000", i, obs, alu, exp_o[i]);
            end
        end
        IR = 32'h0880_0085;
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== F0) begin
            errors++;
            $display("FAIL halt_op_restart: got %h expected %h", obs, F0);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_st();
        test_sub_unknown();
        test_ir_corrupt();
        test_stop_halt();
        test_halt_opcode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
